// File: rtl/eq_engine_tdm.sv
// rtl/eq_engine_tdm.sv - N-band multi-channel cascaded biquad equalizer on one time-shared MAC
// Optional peak meter: define EQ_PEAK_METER_EN to add i_peak_clr / o_peak.
module eq_engine_tdm #(
  parameter int DW     = 16,
  parameter int NBANDS = 6,
  parameter int NCH    = 2,
  parameter int QF     = 14,
  parameter int ACCW   = 40
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic [NCH*DW-1:0]         i_data,
  output logic                      o_ready,
  output logic                      o_valid,
  output logic [NCH*DW-1:0]         o_data,
  output logic                      o_clip,
  input  logic                      i_coef_we,
  input  logic [$clog2(NBANDS)-1:0] i_coef_band,
  input  logic [2:0]                i_coef_idx,
  input  logic [DW-1:0]             i_coef_data,
  input  logic                      i_clear
`ifdef EQ_PEAK_METER_EN
  ,
  input  logic                      i_peak_clr,
  output logic [NCH*DW-1:0]         o_peak
`endif
);

  localparam int BW = $clog2(NBANDS);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic signed [ACCW-1:0] RND  = ACCW'(1) <<< (QF - 1);
  localparam logic signed [ACCW-1:0] SMAX = ACCW'((1 <<< (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] SMIN = -SMAX - ACCW'(1);
  localparam logic signed [DW-1:0]   YMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]   YMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0]   UNITY = DW'(1 << QF);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;
  state_t r_state, w_next;

  logic signed [DW-1:0]   r_coef [NBANDS][5];
  logic signed [DW-1:0]   r_x1 [NCH][NBANDS];
  logic signed [DW-1:0]   r_x2 [NCH][NBANDS];
  logic signed [DW-1:0]   r_y1 [NCH][NBANDS];
  logic signed [DW-1:0]   r_y2 [NCH][NBANDS];
  logic [NCH*DW-1:0]      r_in, r_out;
  logic signed [DW-1:0]   r_x;
  logic signed [ACCW-1:0] r_acc;
  logic [2:0]             r_k;
  logic [BW-1:0]          r_band;
  logic [CW-1:0]          r_ch;
  logic                   r_clip;

  logic signed [DW-1:0]   w_coef, w_y;
  logic signed [ACCW-1:0] w_op, w_prod, w_rnd, w_sh;
  logic                   w_sat, w_last_band, w_last_ch, w_coef_wr;
  logic [CW-1:0]          w_nch;

  assign w_last_band = (int'(r_band) == NBANDS - 1);
  assign w_last_ch   = (int'(r_ch) == NCH - 1);
  assign w_nch       = w_last_ch ? '0 : r_ch + CW'(1);
  assign w_coef_wr   = i_coef_we && (r_state == S_IDLE) &&
                       (int'(i_coef_band) < NBANDS) && (i_coef_idx < 3'd5);
  assign o_data      = r_out;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_clip  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_next = S_MAC;
      end
      S_MAC:  if (r_k == 3'd4) w_next = S_WB;
      S_WB:   if (w_last_band && w_last_ch) w_next = S_DONE;
              else w_next = S_MAC;
      S_DONE: begin
        o_valid = 1'b1;
        o_clip  = r_clip;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Feedback terms enter the sum negated: y = b.x - a.y
  always_comb begin
    w_coef = '0;
    w_op   = '0;
    case (r_k)
      3'd0: begin w_coef = r_coef[r_band][0]; w_op = ACCW'(r_x); end
      3'd1: begin w_coef = r_coef[r_band][1]; w_op = ACCW'(r_x1[r_ch][r_band]); end
      3'd2: begin w_coef = r_coef[r_band][2]; w_op = ACCW'(r_x2[r_ch][r_band]); end
      3'd3: begin w_coef = r_coef[r_band][3]; w_op = -ACCW'(r_y1[r_ch][r_band]); end
      3'd4: begin w_coef = r_coef[r_band][4]; w_op = -ACCW'(r_y2[r_ch][r_band]); end
      default: ;
    endcase
    w_prod = ACCW'(w_coef) * w_op;
    w_rnd  = r_acc + RND;
    w_sh   = w_rnd >>> QF;
    w_sat  = 1'b0;
    if (w_sh > SMAX) begin
      w_y = YMAX; w_sat = 1'b1;
    end else if (w_sh < SMIN) begin
      w_y = YMIN; w_sat = 1'b1;
    end else begin
      w_y = w_sh[DW-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int b = 0; b < NBANDS; b++)
        for (int i = 0; i < 5; i++) r_coef[b][i] <= (i == 0) ? UNITY : '0;
      for (int c = 0; c < NCH; c++)
        for (int b = 0; b < NBANDS; b++) begin
          r_x1[c][b] <= '0; r_x2[c][b] <= '0; r_y1[c][b] <= '0; r_y2[c][b] <= '0;
        end
      r_in <= '0; r_out <= '0; r_x <= '0; r_acc <= '0;
      r_k <= '0; r_band <= '0; r_ch <= '0; r_clip <= 1'b0;
    end else begin
      if (w_coef_wr) r_coef[i_coef_band][i_coef_idx] <= i_coef_data;
      case (r_state)
        S_IDLE: begin
          if (i_clear)
            for (int c = 0; c < NCH; c++)
              for (int b = 0; b < NBANDS; b++) begin
                r_x1[c][b] <= '0; r_x2[c][b] <= '0; r_y1[c][b] <= '0; r_y2[c][b] <= '0;
              end
          if (i_valid) begin
            r_in <= i_data; r_x <= i_data[DW-1:0];
            r_band <= '0; r_ch <= '0; r_k <= '0; r_acc <= '0; r_clip <= 1'b0;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod;
          r_k   <= r_k + 3'd1;
        end
        S_WB: begin
          r_x2[r_ch][r_band] <= r_x1[r_ch][r_band];
          r_x1[r_ch][r_band] <= r_x;
          r_y2[r_ch][r_band] <= r_y1[r_ch][r_band];
          r_y1[r_ch][r_band] <= w_y;
          r_acc <= '0;
          r_k   <= '0;
          if (w_sat) r_clip <= 1'b1;
          if (w_last_band) begin
            r_out[int'(r_ch)*DW +: DW] <= w_y;
            r_band <= '0;
            r_ch   <= w_nch;
            r_x    <= r_in[int'(w_nch)*DW +: DW];
          end else begin
            r_band <= r_band + BW'(1);
            r_x    <= w_y;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef EQ_PEAK_METER_EN
  logic [NCH*DW-1:0] r_peak;
  assign o_peak = r_peak;

  function automatic logic [DW-1:0] f_mag(input logic signed [DW-1:0] v);
    if (v == YMIN)  return YMAX;
    else if (v < 0) return -v;
    else            return v;
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_peak <= '0;
    else if (i_peak_clr) r_peak <= '0;
    else if (r_state == S_DONE)
      for (int c = 0; c < NCH; c++)
        if (f_mag(r_out[c*DW +: DW]) > r_peak[c*DW +: DW])
          r_peak[c*DW +: DW] <= f_mag(r_out[c*DW +: DW]);
  end
`endif

endmodule

// File: tb/tb_eq_engine_tdm.sv
// tb/tb_eq_engine_tdm.sv - self-checking bench for eq_engine_tdm
// Sample-set model with per-band history plus literal expectations; EQ_PEAK_METER_EN aware.
module tb_eq_engine_tdm;
  localparam int DW = 16, NB = 6, NCH = 2, QF = 14;

  logic i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0, i_coef_we = 1'b0, i_clear = 1'b0;
  logic [NCH*DW-1:0] i_data = '0;
  logic [2:0] i_coef_band = '0, i_coef_idx = '0;
  logic [DW-1:0] i_coef_data = '0;
  logic o_ready, o_valid, o_clip;
  logic [NCH*DW-1:0] o_data;
`ifdef EQ_PEAK_METER_EN
  logic i_peak_clr = 1'b0;
  logic [NCH*DW-1:0] o_peak;
`endif

  eq_engine_tdm dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .o_clip(o_clip),
    .i_coef_we(i_coef_we), .i_coef_band(i_coef_band), .i_coef_idx(i_coef_idx),
    .i_coef_data(i_coef_data), .i_clear(i_clear)
`ifdef EQ_PEAK_METER_EN
    , .i_peak_clr(i_peak_clr), .o_peak(o_peak)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {logic [NCH*DW-1:0] d; logic clip;} res_t;

  int n_vec = 0, n_err = 0, n_ovalid = 0;
  int mc [NB][5];
  int mx1 [NCH][NB], mx2 [NCH][NB], my1 [NCH][NB], my2 [NCH][NB];
  int mpeak [NCH];
  res_t exp_q [$];
  res_t mon_e;
  int mon_mag;
  logic [NCH*DW-1:0] got;
  logic gclip;
  int ov0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < NCH; c++)
      for (int b = 0; b < NB; b++) begin
        mx1[c][b] = 0; mx2[c][b] = 0; my1[c][b] = 0; my2[c][b] = 0;
      end
  endfunction

  function automatic void model_reset();
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < 5; i++) mc[b][i] = (i == 0) ? (1 << QF) : 0;
    model_clear();
    for (int c = 0; c < NCH; c++) mpeak[c] = 0;
  endfunction

  // y = sat(round_half_up((b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2) / 2^QF))
  function automatic res_t model_run(input int in0, input int in1);
    res_t r;
    longint acc, q;
    int x, y;
    r.d = '0;
    r.clip = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      x = (c == 0) ? in0 : in1;
      for (int b = 0; b < NB; b++) begin
        acc = longint'(mc[b][0]) * x + longint'(mc[b][1]) * mx1[c][b]
            + longint'(mc[b][2]) * mx2[c][b] - longint'(mc[b][3]) * my1[c][b]
            - longint'(mc[b][4]) * my2[c][b];
        q = (acc + (longint'(1) << (QF - 1))) >>> QF;
        if (q > 32767) begin y = 32767; r.clip = 1'b1; end
        else if (q < -32768) begin y = -32768; r.clip = 1'b1; end
        else y = int'(q);
        mx2[c][b] = mx1[c][b]; mx1[c][b] = x;
        my2[c][b] = my1[c][b]; my1[c][b] = y;
        x = y;
      end
      r.d[c*DW +: DW] = DW'(x);
    end
    return r;
  endfunction

  task automatic coef_wr(input int band, input int idx, input int val);
    i_coef_we = 1'b1; i_coef_band = 3'(band); i_coef_idx = 3'(idx); i_coef_data = DW'(val);
    @(posedge i_clk);
    if (band < NB && idx < 5) mc[band][idx] = val;
    @(negedge i_clk);
    i_coef_we = 1'b0;
  endtask

  task automatic send(input int d0, input int d1, input bit clr,
                      output logic [NCH*DW-1:0] g, output logic gc);
    int lat;
    if (clr) model_clear();
    exp_q.push_back(model_run(d0, d1));
    i_valid = 1'b1; i_clear = clr; i_data = {DW'(d1), DW'(d0)};
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0; i_clear = 1'b0;
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(negedge i_clk);
      lat++;
    end
    chk("latency", lat, 73);
    g = o_data; gc = o_clip;
    @(negedge i_clk);
  endtask

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_valid) begin
        n_ovalid++;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_o_valid: got 1 expected 0");
        end else begin
          mon_e = exp_q.pop_front();
          for (int c = 0; c < NCH; c++) begin
            chk("model_o_data", o_data[c*DW +: DW], mon_e.d[c*DW +: DW]);
            mon_mag = $signed(mon_e.d[c*DW +: DW]);
            if (mon_mag < 0) mon_mag = (mon_mag == -32768) ? 32767 : -mon_mag;
            if (mon_mag > mpeak[c]) mpeak[c] = mon_mag;
          end
          chk("model_o_clip", o_clip, mon_e.clip);
        end
      end
`ifdef EQ_PEAK_METER_EN
      else
        for (int c = 0; c < NCH; c++) chk("o_peak", o_peak[c*DW +: DW], mpeak[c]);
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(negedge i_clk);
    chk("rst_o_ready", o_ready, 1);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_o_clip", o_clip, 0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Passthrough after reset, including the most negative sample
    send('h1234, -32768, 1'b0, got, gclip);
    chk("pass_ch0", got[15:0], 'h1234);
    chk("pass_ch1", got[31:16], 'h8000);
    chk("pass_clip", gclip, 0);

    // Half gain in band 0 and round-half-up
    coef_wr(0, 0, 'h2000);
    send(1000, 1000, 1'b0, got, gclip);
    chk("half_ch0", $signed(got[15:0]), 500);
    send(-1, 3, 1'b0, got, gclip);
    chk("half_neg_round", $signed(got[15:0]), 0);
    chk("half_pos_round", $signed(got[31:16]), 2);

    // Out-of-range coefficient targets are ignored
    coef_wr(0, 5, 0);
    coef_wr(6, 0, 0);
    coef_wr(7, 0, 0);
    send(1000, -1000, 1'b0, got, gclip);
    chk("ign_ch0", $signed(got[15:0]), 500);
    chk("ign_ch1", $signed(got[31:16]), -500);

    // Saturation both ways, then a clean set clears o_clip
    coef_wr(0, 0, 'h7FFF);
    coef_wr(1, 0, 'h7FFF);
    send(32767, 0, 1'b0, got, gclip);
    chk("sat_pos", got[15:0], 'h7FFF);
    chk("sat_pos_clip", gclip, 1);
    send(-32768, 0, 1'b0, got, gclip);
    chk("sat_neg", got[15:0], 'h8000);
    chk("sat_neg_clip", gclip, 1);
    send(0, 0, 1'b0, got, gclip);
    chk("noclip_after", gclip, 0);
    coef_wr(0, 0, 16384);
    coef_wr(1, 0, 16384);

    // Recursive impulse response, clear together with the first accept
    coef_wr(0, 3, -8192);
    for (int i = 0; i < 4; i++) begin
      send((i == 0) ? 16384 : 0, 0, (i == 0), got, gclip);
      chk("impulse", $signed(got[15:0]), 16384 >>> i);
    end
    coef_wr(0, 3, 0);

    // Busy-time i_valid and coefficient write are dropped
    ov0 = n_ovalid;
    fork
      send(1000, 2000, 1'b0, got, gclip);
      begin
        repeat (10) @(negedge i_clk);
        chk("busy_ready", o_ready, 0);
        i_valid = 1'b1; i_data = {16'd7, 16'd7};
        i_coef_we = 1'b1; i_coef_band = 3'd0; i_coef_idx = 3'd0; i_coef_data = 16'h1000;
        @(negedge i_clk);
        i_valid = 1'b0; i_coef_we = 1'b0;
      end
    join
    repeat (100) @(negedge i_clk);
    chk("busy_ovalid_count", n_ovalid - ov0, 1);
    send(300, -300, 1'b0, got, gclip);
    chk("busy_old_coef_ch0", $signed(got[15:0]), 300);
    chk("busy_old_coef_ch1", $signed(got[31:16]), -300);

`ifdef EQ_PEAK_METER_EN
    i_peak_clr = 1'b1;
    @(posedge i_clk);
    for (int c = 0; c < NCH; c++) mpeak[c] = 0;
    @(negedge i_clk);
    i_peak_clr = 1'b0;
    chk("peak_clr", o_peak, 0);
`endif

    // Reset in the middle of a run
    coef_wr(2, 0, 8192);
    i_valid = 1'b1; i_data = {16'd111, 16'd222};
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (29) @(negedge i_clk);
    i_rst = 1'b1;
    exp_q.delete();
    model_reset();
    @(negedge i_clk);
    chk("midrst_o_ready", o_ready, 1);
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_o_data", o_data, 0);
    chk("midrst_o_clip", o_clip, 0);
    i_rst = 1'b0;
    ov0 = n_ovalid;
    repeat (100) @(negedge i_clk);
    chk("midrst_no_ovalid", n_ovalid - ov0, 0);
    send(1234, -5678, 1'b0, got, gclip);
    chk("post_rst_ch0", $signed(got[15:0]), 1234);
    chk("post_rst_ch1", $signed(got[31:16]), -5678);
    chk("post_rst_clip", gclip, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
